// File: rtl/weight_dma_loader.sv
// Weight FIFO write-side loader: packs a byte stream into 24-bit words
// and writes them to the selected weight buffer.
module weight_dma_loader #(
    parameter int DATA_WIDTH     = 24,
    parameter int BYTES_PER_WORD = 3,
    parameter int CNT_WIDTH      = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  buf_sel_in,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wt_buf_sel,
    input  logic                  fifo_wr_full,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  words_written
);

    localparam int IDX_W =
        (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  target_q, target_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic                  sel_q, sel_d;

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pack_d   = pack_q;
        idx_d    = idx_q;
        target_d = target_q;
        count_d  = count_q;
        sel_d    = sel_q;
        s_ready  = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d    = buf_sel_in;
                    target_d = num_words;
                    count_d  = '0;
                    idx_d    = '0;
                    pack_d   = '0;
                    state_d  = (num_words == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                s_ready = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (s_valid) begin
                    pack_d[{idx_q, 3'b000} +: 8] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                // Write strobe follows the full flag combinationally.
                if (abort) begin
                    state_d = IDLE;
                end else if (!fifo_wr_full) begin
                    wr_en   = 1'b1;
                    count_d = count_inc;
                    idx_d   = '0;
                    state_d = (count_inc == target_q) ? DONE : COLLECT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pack_q   <= '0;
            idx_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pack_q   <= pack_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            count_q  <= count_d;
            sel_q    <= sel_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign wr_data       = pack_q;
    assign wt_buf_sel    = sel_q;
    assign words_written = count_q;

endmodule

// File: tb/tb_weight_dma_loader.sv
// Bench for weight_dma_loader: queue-based reference model plus
// directed load scenarios with literal expectations.
module tb_weight_dma_loader;

    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          buf_sel_in = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          fifo_wr_full = 1'b0;
    logic          s_ready, wr_en, wt_buf_sel, busy, done;
    logic [23:0]   wr_data;
    logic [CW-1:0] words_written;

    int errors = 0;
    int checks = 0;
    int n_writes = 0;
    bit chk_en = 1'b0;
    bit bubble = 1'b0;
    bit acc_q = 1'b0;
    byte unsigned feed[$];

    always #5 clk = ~clk;

    weight_dma_loader #(
        .DATA_WIDTH(24),
        .BYTES_PER_WORD(3),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .buf_sel_in(buf_sel_in),
        .num_words(num_words),
        .abort(abort),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wt_buf_sel(wt_buf_sel),
        .fifo_wr_full(fifo_wr_full),
        .busy(busy),
        .done(done),
        .words_written(words_written)
    );

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Reference model: a load is a count of words to emit, each word
    // being the next three accepted bytes, LSB first.
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    bit          m_sel = 1'b0;
    int          m_written = 0;
    int          m_target = 0;
    byte unsigned m_bytes[$];
    logic [23:0] m_word;

    always @(negedge clk) begin
        acc_q <= s_valid && s_ready;
        if (chk_en) begin
            chk("busy", busy, m_active || m_done);
            chk("done", done, m_done);
            chk("s_ready", s_ready, m_active && m_bytes.size() < 3);
            chk("wr_en", wr_en, m_active && m_bytes.size() == 3
                                && !fifo_wr_full && !abort);
            chk("wt_buf_sel", wt_buf_sel, m_sel);
            chk("words_written", words_written, m_written);
            if (m_active && m_bytes.size() == 3) begin
                m_word = {m_bytes[2], m_bytes[1], m_bytes[0]};
                chk("wr_data", wr_data, m_word);
            end
            if (wr_en) n_writes++;
        end
        if (rst) begin
            m_active = 1'b0;
            m_done = 1'b0;
            m_sel = 1'b0;
            m_written = 0;
            m_target = 0;
            m_bytes.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_sel = buf_sel_in;
                m_target = int'(num_words);
                m_written = 0;
                m_bytes.delete();
                if (num_words == '0) m_done = 1'b1;
                else m_active = 1'b1;
            end
        end else if (abort) begin
            m_active = 1'b0;
            m_bytes.delete();
        end else if (m_bytes.size() < 3) begin
            if (s_valid) m_bytes.push_back(s_data);
        end else if (!fifo_wr_full) begin
            m_written++;
            m_bytes.delete();
            if (m_written == m_target) begin
                m_active = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_q && feed.size() > 0) void'(feed.pop_front());
        s_valid = (feed.size() > 0) && !bubble;
        s_data = (feed.size() > 0) ? feed[0] : 8'h00;
    endtask

    task automatic push3(input logic [23:0] w);
        feed.push_back(w[7:0]);
        feed.push_back(w[15:8]);
        feed.push_back(w[23:16]);
    endtask

    task automatic do_start(input int n, input bit sel);
        start = 1'b1;
        buf_sel_in = sel;
        num_words = CW'(n);
        step();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int w0;
        bit got;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_sel", wt_buf_sel, 0);
        chk("rst_done", done, 0);
        chk("rst_count", words_written, 0);
        step();

        // two-word load, back-to-back bytes
        push3(24'h332211);
        push3(24'h665544);
        do_start(2, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("t1_wr_en_c4", wr_en, 1);
        chk("t1_data_c4", wr_data, 24'h332211);
        repeat (4) step();
        @(negedge clk);
        chk("t1_wr_en_c8", wr_en, 1);
        chk("t1_data_c8", wr_data, 24'h665544);
        step();
        @(negedge clk);
        chk("t1_done_c9", done, 1);
        chk("t1_count_c9", words_written, 2);
        step();
        @(negedge clk);
        chk("t1_busy_c10", busy, 0);
        step();

        // backpressure for five cycles on entry to WRITE
        push3(24'h030201);
        fifo_wr_full = 1'b1;
        w0 = n_writes;
        do_start(1, 1'b0);
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_wr_en", wr_en, 0);
            chk("t2_hold_s_ready", s_ready, 0);
            chk("t2_hold_data", wr_data, 24'h030201);
            step();
        end
        fifo_wr_full = 1'b0;
        @(negedge clk);
        chk("t2_release_wr_en", wr_en, 1);
        step();
        chk("t2_one_write", n_writes - w0, 1);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_count", words_written, 1);
        step();

        // zero-length load
        w0 = n_writes;
        do_start(0, 1'b0);
        @(negedge clk);
        chk("t3_done_c1", done, 1);
        chk("t3_wr_en", wr_en, 0);
        chk("t3_s_ready", s_ready, 0);
        chk("t3_count", words_written, 0);
        step();
        chk("t3_no_write", n_writes - w0, 0);
        @(negedge clk);
        chk("t3_busy_c2", busy, 0);
        step();

        // abort after two bytes, then a clean one-word load
        w0 = n_writes;
        feed.push_back(8'hDE);
        feed.push_back(8'hAD);
        do_start(3, 1'b0);
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        step();
        chk("t4_no_write", n_writes - w0, 0);
        push3(24'hCCBBAA);
        do_start(1, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("t4_wr_en", wr_en, 1);
        chk("t4_data", wr_data, 24'hCCBBAA);
        step();
        @(negedge clk);
        chk("t4_done", done, 1);
        step();

        // buffer select held; start while busy ignored; s_valid bubble
        w0 = n_writes;
        push3(24'h33CC55);
        push3(24'h77EE99);
        do_start(2, 1'b1);
        step();
        start = 1'b1;
        buf_sel_in = 1'b0;
        num_words = CW'(5);
        step();
        start = 1'b0;
        bubble = 1'b1;
        repeat (2) step();
        bubble = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else step();
        end
        chk("t5_done_seen", got, 1);
        chk("t5_count", words_written, 2);
        chk("t5_sel_done", wt_buf_sel, 1);
        step();
        chk("t5_two_writes", n_writes - w0, 2);
        @(negedge clk);
        chk("t5_idle_busy", busy, 0);
        chk("t5_sel_idle", wt_buf_sel, 1);
        step();

        // reset while stalled in WRITE
        push3(24'h445566);
        fifo_wr_full = 1'b1;
        w0 = n_writes;
        do_start(1, 1'b1);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        fifo_wr_full = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_s_ready", s_ready, 0);
        chk("t6_wr_en", wr_en, 0);
        chk("t6_wr_data", wr_data, 0);
        chk("t6_sel", wt_buf_sel, 0);
        chk("t6_done", done, 0);
        chk("t6_count", words_written, 0);
        step();
        chk("t6_no_write", n_writes - w0, 0);
        push3(24'h0C0B0A);
        do_start(1, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("t6_post_wr_en", wr_en, 1);
        chk("t6_post_data", wr_data, 24'h0C0B0A);
        step();
        @(negedge clk);
        chk("t6_post_done", done, 1);
        chk("t6_post_count", words_written, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_dma_loader.md
# weight_dma_loader

Write-side producer for the double-buffered weight FIFO. Accepts a byte stream from the host/DMA path, packs every three bytes into one 24-bit weight word, and pushes words into the FIFO's write port while honouring its full flag. It drives the FIFO's buffer-select line for the duration of a load and reports completion once the programmed word count has been written.

## Interface
- DATA_WIDTH, 24, packed word width; must equal 8 × BYTES_PER_WORD.
- BYTES_PER_WORD, 3, bytes packed per FIFO word.
- CNT_WIDTH, 13, width of word counters; must cover FIFO depth 4096.

- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse that begins a load; ignored unless the block is idle.
- buf_sel_in  in  1  target buffer, sampled with start.
- num_words  in  CNT_WIDTH  words to load, sampled with start.
- abort  in  1  synchronous cancel of the current load.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  byte-stream ready; a byte transfers when s_valid && s_ready.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  DATA_WIDTH  FIFO write data.
- wt_buf_sel  out  1  FIFO buffer select; holds the latched buf_sel_in.
- fifo_wr_full  in  1  FIFO full flag for the selected buffer.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse marking load completion.
- words_written  out  CNT_WIDTH  words written in the current or most recent load.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - On start: latch buf_sel_in into wt_buf_sel, latch num_words, clear words_written and the byte index.
  - If num_words == 0, go to DONE; otherwise go to COLLECT.
- COLLECT: s_ready = 1.
  - Each accepted byte k (k = 0..2) is written to pack register bits [8k+7:8k], so byte 0 is the LSB.
  - After byte 2 is accepted, go to WRITE.
- WRITE: s_ready = 0; wr_en = !fifo_wr_full (combinational); wr_data = pack register.
  - If full: stay in WRITE and hold wr_data.
  - If not full: the write happens this cycle and words_written increments.
  - If the new count equals num_words, go to DONE; otherwise go to COLLECT with the byte index cleared.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- wt_buf_sel changes only on an accepted start and holds across IDLE so the reader side keeps its selection.
- A start while busy is ignored: latched values are unchanged and no state change occurs.
- Abort, in any non-IDLE state: next state is IDLE, a partial word is discarded, and done is not asserted.
  - wr_en is forced 0 in the abort cycle.
  - words_written keeps its value.
  - Abort has priority over start and over the WRITE transition.
- rst has priority over everything and returns the block to IDLE.
- Reset values:
  - s_ready = 0, wr_en = 0, wr_data = 0, wt_buf_sel = 0.
  - busy = 0, done = 0, words_written = 0.
  - Pack register and byte index = 0.
- Counter arithmetic is CNT_WIDTH unsigned, with no wrap within a load because num_words ≤ 4096.

## Timing
- Start is sampled at edge 0. COLLECT is entered at cycle 1, where s_ready = 1.
- With s_valid held high, bytes are accepted at cycles 1, 2 and 3. WRITE is at cycle 4, with wr_en = 1 if not full.
- Steady-state throughput is 4 cycles per word with no backpressure.
- Each cycle of fifo_wr_full = 1 in WRITE adds exactly one cycle.
- If the last write is at cycle W: done = 1 at W+1, busy = 0 at W+2, and a new start is accepted at W+2.
- num_words = 0: done = 1 at cycle 1, with no wr_en and no s_ready.
- Bubbles on s_valid stretch COLLECT only. The byte index advances only on accepted bytes.

## Test plan
- Two-word load: num_words = 2, bytes 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 back-to-back.
  - Expect wr_en at cycle 4 with wr_data = 0x332211, and at cycle 8 with 0x665544.
  - Expect done at cycle 9, words_written = 2, busy low at cycle 10.
- Backpressure: fifo_wr_full = 1 for 5 cycles on entry to WRITE.
  - Expect wr_en = 0 and s_ready = 0 throughout, with wr_data stable.
  - Expect exactly one write on release; words_written increments once.
- Zero-length load: num_words = 0.
  - Expect done = 1 at cycle 1, no wr_en, no s_ready, words_written = 0.
- Abort after 2 bytes, then start with num_words = 1 and bytes 0xAA, 0xBB, 0xCC.
  - Expect no write and no done from the aborted load.
  - Expect the new load to write 0xCCBBAA; the discarded partial bytes must not leak into it.
- Buffer select: start with buf_sel_in = 1, then a second start with buf_sel_in = 0 mid-load.
  - Expect wt_buf_sel to stay 1 through done and idle.
  - Expect the second start to be ignored: count is unchanged and only the first load's words are written.
- Reset mid-WRITE with fifo_wr_full = 1.
  - Expect all outputs at reset values the next cycle and no wr_en pulse.
  - Expect a subsequent one-word load to work normally.
